// File: rtl/sha_block_sequencer.sv
// Loads one 256-bit chunk and its expected digest into the sha256 core and reports pass/fail.
// Optional macro SHA_SEQ_LOCK_ON_FAIL_EN: first fail latches locked_o until rst_i.
module sha_block_sequencer #(
  parameter int SHA_TIMEOUT = 100,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [255:0]     block_i,
  input  logic [255:0]     digest_i,
  output logic             ready_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             sha_reset_n_o,
  output logic             sha_cs_o,
  output logic             sha_we_o,
  output logic             sha_wc_o,
  output logic [2:0]       sha_address_o,
  output logic [31:0]      sha_write_data_o,
  input  logic             sha_digest_valid_i
);

  localparam int TMR_W = $clog2(SHA_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SHA_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LOAD_BLK, S_LOAD_DIG, S_GO, S_WAIT, S_PASS, S_FAIL, S_CLR_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [255:0]     block_q, digest_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic             live_q;
  logic             locked;
  logic             accept;

  // live_q keeps ready_o and sha_reset_n_o low until the first edge after reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) live_q <= 1'b0;
    else       live_q <= 1'b1;
  end

`ifdef SHA_SEQ_LOCK_ON_FAIL_EN
  logic locked_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 locked_q <= 1'b0;
    else if (state_q == S_FAIL) locked_q <= 1'b1;
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign locked_o = locked;
  assign ready_o  = live_q & ~locked & (state_q == S_IDLE);
  assign accept   = ready_o & start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      tmr_q      <= '0;
      block_q    <= '0;
      digest_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      if (accept) begin
        block_q  <= block_i;
        digest_q <= digest_i;
      end
      if (state_q == S_PASS && pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      if (state_q == S_FAIL && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    tmr_d            = tmr_q;
    sha_reset_n_o    = live_q & ~locked;
    sha_cs_o         = 1'b0;
    sha_we_o         = 1'b0;
    sha_wc_o         = 1'b0;
    sha_address_o    = '0;
    sha_write_data_o = '0;
    pass_o           = 1'b0;
    fail_o           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CLR;
          k_d     = '0;
        end
      end
      S_CLR: begin
        sha_reset_n_o = 1'b0;
        k_d           = '0;
        state_d       = S_LOAD_BLK;
      end
      S_LOAD_BLK: begin
        sha_cs_o         = 1'b1;
        sha_we_o         = 1'b1;
        sha_address_o    = k_q;
        sha_write_data_o = block_q[{k_q, 5'd0} +: 32];
        k_d              = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_LOAD_DIG;
      end
      S_LOAD_DIG: begin
        sha_cs_o         = 1'b1;
        sha_wc_o         = 1'b1;
        sha_address_o    = k_q;
        sha_write_data_o = digest_q[{k_q, 5'd0} +: 32];
        k_d              = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_GO;
      end
      S_GO: begin
        sha_cs_o = 1'b1;
        tmr_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        // valid on the last timer cycle still counts as a pass
        if (sha_digest_valid_i)    state_d = S_PASS;
        else if (tmr_q == TMR_LAST) state_d = S_FAIL;
      end
      S_PASS: begin
        pass_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        fail_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_CLR_ABORT: begin
        sha_reset_n_o = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i && state_q != S_IDLE) state_d = S_CLR_ABORT;
  end

  assign pass_cnt_o = pass_cnt_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Self-checking bench for sha_block_sequencer: vector table, random chunks, reset corner cases.
module tb_sha_block_sequencer;

  localparam int SHA_TIMEOUT = 100;
  localparam int CNT_W       = 16;
`ifdef SHA_SEQ_LOCK_ON_FAIL_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i, start_i, abort_i, valid_i;
  logic [255:0]     block_i, digest_i;
  logic             ready_o, pass_o, fail_o, locked_o;
  logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o;
  logic             sha_reset_n_o, sha_cs_o, sha_we_o, sha_wc_o;
  logic [2:0]       sha_address_o;
  logic [31:0]      sha_write_data_o;

  sha_block_sequencer #(.SHA_TIMEOUT(SHA_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .block_i(block_i), .digest_i(digest_i), .ready_o(ready_o),
    .pass_o(pass_o), .fail_o(fail_o), .locked_o(locked_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .sha_reset_n_o(sha_reset_n_o), .sha_cs_o(sha_cs_o), .sha_we_o(sha_we_o),
    .sha_wc_o(sha_wc_o), .sha_address_o(sha_address_o),
    .sha_write_data_o(sha_write_data_o), .sha_digest_valid_i(valid_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rn, cs, we, wc;
    logic [2:0] a;
    logic [31:0] wd;
    logic rdy, ps, fl, lk;
  } obs_t;

  typedef struct {
    logic [255:0] blk, dig;
    int vd, ab;
    int exp_pass, exp_fail;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_pcnt = 0;
  int exp_fcnt = 0;
  bit exp_locked = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '{sha_reset_n_o, sha_cs_o, sha_we_o, sha_wc_o, sha_address_o, sha_write_data_o,
          ready_o, pass_o, fail_o, locked_o};
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Expected outputs t edges after the accepting edge, from the chunk timeline:
  // CLR, 8 block words, 8 digest words, GO, WAIT until res_t, result, IDLE.
  function automatic obs_t model(int t, int res_t, bit is_pass, int ab,
                                 logic [255:0] blk, logic [255:0] dig, bit lk);
    obs_t e;
    e    = '0;
    e.lk = lk;
    e.rn = 1'b1;
    if (ab >= 0 && ab <= res_t && t > ab) begin
      if (t == ab + 1) e.rn = 1'b0;
      else begin e.rn = !lk; e.rdy = !lk; end
    end else if (t == 0) e.rn = 1'b0;
    else if (t <= 8) begin
      e.cs = 1'b1; e.we = 1'b1; e.a = 3'(t - 1); e.wd = blk[32*(t-1) +: 32];
    end else if (t <= 16) begin
      e.cs = 1'b1; e.wc = 1'b1; e.a = 3'(t - 9); e.wd = dig[32*(t-9) +: 32];
    end else if (t == 17) e.cs = 1'b1;
    else if (t < res_t) begin
    end else if (t == res_t) begin
      e.ps = is_pass; e.fl = !is_pass;
    end else begin
      e.rn = !lk; e.rdy = !lk;
    end
    return e;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, " pass_cnt"}, 256'(pass_cnt_o), 256'(exp_pcnt));
    chk({tag, " fail_cnt"}, 256'(fail_cnt_o), 256'(exp_fcnt));
  endtask

  // Entered and left at a negedge with the DUT idle. vd<0 means valid never comes;
  // ab>=0 raises abort for the cycle that follows edge ab.
  task automatic run_chunk(input logic [255:0] blk, input logic [255:0] dig,
                           input int vd, input int ab, output int npass, output int nfail);
    int res_t, last;
    bit is_pass;
    obs_t e;
    npass = 0;
    nfail = 0;
    block_i  = blk;
    digest_i = dig;
    abort_i  = 1'b0;
    valid_i  = 1'b0;
    if (exp_locked) begin
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        start_i = 1'b0;
        e = '0;
        e.lk = 1'b1;
        chk($sformatf("locked idle %0d", i), 256'(observe()), 256'(e));
        chk_cnt("locked");
      end
      return;
    end
    chk("ready before start", 256'(ready_o), 256'(1));
    start_i = 1'b1;
    is_pass = (vd >= 0 && vd < SHA_TIMEOUT);
    res_t   = is_pass ? 19 + vd : 18 + SHA_TIMEOUT;
    last    = (ab >= 0 && ab <= res_t) ? ab + 2 : res_t + 1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      e = model(t, res_t, is_pass, ab, blk, dig, exp_locked);
      chk($sformatf("cycle t=%0d", t), 256'(observe()), 256'(e));
      chk_cnt($sformatf("t=%0d", t));
      if (pass_o === 1'b1) npass++;
      if (fail_o === 1'b1) nfail++;
      if (e.ps) exp_pcnt++;
      if (e.fl) begin
        exp_fcnt++;
        if (LOCK_EN) exp_locked = 1'b1;
      end
      start_i  = (t < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort_i  = (t == ab) && (t < last);
      block_i  = rand256();
      digest_i = rand256();
      valid_i  = (t < 18) ? 1'($urandom_range(0, 1)) : (t == 18 + vd);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    exp_pcnt   = 0;
    exp_fcnt   = 0;
    exp_locked = 1'b0;
  endtask

  vec_t vec[7];
  int   np, nf, vd, ab;
  bit   was_locked;
  obs_t e;

  initial begin
    vec[0] = '{{4{64'h0123456789abcdef}},
               {32'h45dfe6e6, 192'h0a1b2c3d4e5f60718293a4b5c6d7e8f90011223344556677, 32'h58dc0753},
               64, -1, 1, 0};
    vec[1] = '{{4{64'h0123456789abcdef}},
               {32'h45dfe6e6, 96'h0a1b2c3d4e5f607182930011, 32'hf1b3e544, 64'h2233445566778899, 32'h58dc0753},
               -1, -1, 0, 1};
    vec[2] = '{256'h1, 256'h2, 0, -1, 1, 0};
    vec[3] = '{{8{32'hdeadbeef}}, {8{32'hcafef00d}}, SHA_TIMEOUT - 1, -1, 1, 0};
    vec[4] = '{{8{32'h11112222}}, {8{32'h33334444}}, SHA_TIMEOUT, -1, 0, 1};
    vec[5] = '{{8{32'h55556666}}, {8{32'h77778888}}, 10, 12, 0, 0};
    vec[6] = '{{8{32'h9999aaaa}}, {8{32'hbbbbcccc}}, 5, 24, 1, 0};

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0;
    block_i = '0; digest_i = '0;
    #1;
    chk("reset outputs", 256'(observe()), 256'(0));
    chk_cnt("reset");
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("ready before first edge", 256'({ready_o, sha_reset_n_o}), 256'(0));
    @(negedge clk);
    e = '0; e.rn = 1'b1; e.rdy = 1'b1;
    chk("idle after reset", 256'(observe()), 256'(e));

    for (int i = 0; i < 7; i++) begin
      was_locked = exp_locked;
      run_chunk(vec[i].blk, vec[i].dig, vec[i].vd, vec[i].ab, np, nf);
      chk($sformatf("vec%0d pass pulses", i), 256'(np), 256'(was_locked ? 0 : vec[i].exp_pass));
      chk($sformatf("vec%0d fail pulses", i), 256'(nf), 256'(was_locked ? 0 : vec[i].exp_fail));
      if (i == 2) begin
        chk("seq pass_cnt", 256'(pass_cnt_o), 256'(LOCK_EN ? 1 : 2));
        chk("seq fail_cnt", 256'(fail_cnt_o), 256'(1));
      end
    end

    // Asynchronous reset in the middle of WAIT, with non-zero counters beforehand
    do_reset();
    run_chunk(rand256(), rand256(), 3, -1, np, nf);
    start_i = 1'b1;
    block_i = rand256();
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async reset outputs", 256'(observe()), 256'(0));
    exp_pcnt = 0; exp_fcnt = 0; exp_locked = 1'b0;
    chk_cnt("async reset");
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("released before edge", 256'(observe()), 256'(0));
    @(negedge clk);
    e = '0; e.rn = 1'b1; e.rdy = 1'b1;
    chk("idle after release", 256'(observe()), 256'(e));

    for (int i = 0; i < 14; i++) begin
      vd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, SHA_TIMEOUT + 5));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_chunk(rand256(), rand256(), vd, ab, np, nf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
